mem_stall_ctrl: RTL and testbench
=================================

Name: mem_stall_ctrl

Overview:
Parametrised memory-stall and pipeline-enable controller for the pipelined RISC-V core on the Avalon bus. It tracks PORTS independent memory channels (e.g. instruction fetch, data read, data write) through a request/done handshake and freezes a per-port, configurable subset of pipeline stages and the PC while a channel is outstanding. It adds a per-port timeout with sticky error reporting, and a zero-wait completion path for single-cycle memories.

Parameters:
STAGES, 4, number of pipeline register stages (bit 0 = IF/ID ... STAGES-1 = MEM/WB)
PORTS, 2, number of memory channels
TIMEOUT, 16, max cycles a channel may wait for done before abort (>=2)
HOLD_MASK, {PORTS{(STAGES+1){1'b1}}}, per port p, bits [p*(STAGES+1) +: STAGES+1]; bit s<STAGES freezes stage s; bit STAGES freezes the PC

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous reset, active-high
enable_in  in  STAGES  upstream stage enables (debug/hazard), passed through when no stall
enable_pc_in  in  1  upstream PC enable
req  in  PORTS  per-port request level from pipeline (read/write strobe)
done  in  PORTS  per-port completion from memory
err_clr  in  PORTS  per-port clear of sticky error
enable_out  out  STAGES  gated stage enables
enable_pc_out  out  1  gated PC enable
mem_strobe  out  PORTS  request to memory, held until completion
busy  out  PORTS  port is in WAIT
err  out  PORTS  sticky timeout flag
step  out  1  equals enable_pc_out (single-step indicator)

Behaviour:
- Reset (RST=1 at posedge): all ports IDLE, counters 0, err=0. Output values while reset is held: mem_strobe=0, busy=0, and the stall term is 0, so enable_out=enable_in and enable_pc_out=enable_pc_in.
- Per-port FSM, states IDLE, WAIT, HOLD, described below.
- IDLE: when req[p]=1, mem_strobe[p]=1 combinationally in the same cycle. If done[p]=1 in that same cycle, the access completes with zero wait and the next state is HOLD. Otherwise the next state is WAIT, with the counter loaded to 1.
- WAIT: mem_strobe[p]=1 and busy[p]=1. If done[p]=1, the next state is HOLD. Else, if the counter equals TIMEOUT-1, the next state is HOLD and err[p] is set. Else the counter increments.
- HOLD: lasts exactly 1 cycle; mem_strobe[p]=0 and req[p] is ignored, so a req still high does not retrigger. Next state is IDLE.
- pending[p] = mem_strobe[p] & ~done[p].
- stall[s] = OR over p of (pending[p] & HOLD_MASK bit s of port p). stall_pc is the same using bit STAGES.
- enable_out[s] = enable_in[s] & ~stall[s]. enable_pc_out = enable_pc_in & ~stall_pc. All are combinational, with zero cycles of latency from done to release.
- Timeout abort: the stall releases in the cycle the port leaves WAIT. A done[p] arriving after that is ignored, i.e. treated as a spurious done.
- Spurious done[p] in IDLE or HOLD: no effect.
- err[p]: set on timeout. Cleared by err_clr[p] or by RST. If set and clear occur in the same cycle, set wins.
- Ports are fully independent. Simultaneous stalls from several ports OR together, and a stage is released only when every masked port is non-pending.
- Reset mid-transaction: the FSM returns to IDLE on the next edge, with no HOLD cycle and the counter zeroed. The memory side sees mem_strobe drop.
- Counter width is clog2(TIMEOUT)+1. The counter saturates and never wraps.

Test Plan:
1. Zero-wait: PORTS=2, req[0]=1 and done[0]=1 in cycle 0 → enable_out=enable_in=4'hF throughout. mem_strobe[0]=1 for cycle 0 only, cycle 1 is HOLD, and req still high in cycle 1 does not restart the access.
2. Wait-state read: req[1] rises at cycle 0, done[1] at cycle 3, HOLD_MASK all ones → enable_out=0 and enable_pc_out=0 for cycles 0-2. Enables are released in cycle 3, busy[1]=1 in cycles 1-3, and mem_strobe[1] drops at cycle 4.
3. Partial mask: port 0 mask = 5'b10001 (stage 0 and PC only), req[0] pending 3 cycles → enable_out=4'b1110 and enable_pc_out=0 during the wait. Stages 1-3 keep advancing.
4. Overlap: port 0 done at cycle 2, port 1 done at cycle 5, both with full masks → enables stay 0 through cycle 4 and are released at cycle 5.
5. Timeout: TIMEOUT=16, req[0] held, done never asserted → stall lasts 16 cycles (cycle 0 through cycle 15). Then err[0]=1 and HOLD, and a late done[0] has no effect. err_clr[0] pulse → err[0]=0 next cycle.
6. Reset mid-wait: RST=1 at cycle 2 of a wait → at the next edge busy=0, mem_strobe=0, err=0, and the counter is 0. The state is IDLE, with no HOLD cycle.

Source files
------------

// File: rtl/mem_stall_ctrl.sv
// Memory-stall and pipeline-enable controller: per-port request/done tracking with
// timeout abort, sticky error, and combinational freeze of masked stages and the PC.
module mem_stall_ctrl #(
   parameter int STAGES  = 4,
   parameter int PORTS   = 2,
   parameter int TIMEOUT = 16,
   parameter logic [PORTS*(STAGES+1)-1:0] HOLD_MASK = {PORTS*(STAGES+1){1'b1}}
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [STAGES-1:0]    enable_in,
   input  logic                 enable_pc_in,
   input  logic [PORTS-1:0]     req,
   input  logic [PORTS-1:0]     done,
   input  logic [PORTS-1:0]     err_clr,
   output logic [STAGES-1:0]    enable_out,
   output logic                 enable_pc_out,
   output logic [PORTS-1:0]     mem_strobe,
   output logic [PORTS-1:0]     busy,
   output logic [PORTS-1:0]     err,
   output logic                 step,
   output logic [2*PORTS-1:0]   dbg_state
);

   localparam int CW = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t          state_q [PORTS];
   state_t          state_d [PORTS];
   logic [CW-1:0]   cnt_q   [PORTS];
   logic [CW-1:0]   cnt_d   [PORTS];
   logic [PORTS-1:0] err_q, err_d;
   logic [PORTS-1:0] strobe_raw, busy_raw, pending;
   logic [STAGES:0]  stall;

   always_comb begin
      for (int p = 0; p < PORTS; p++) begin
         state_d[p]    = state_q[p];
         cnt_d[p]      = cnt_q[p];
         err_d[p]      = err_q[p] & ~err_clr[p];
         strobe_raw[p] = 1'b0;
         busy_raw[p]   = 1'b0;
         case (state_q[p])
            S_IDLE: begin
               if (req[p]) begin
                  strobe_raw[p] = 1'b1;
                  if (done[p]) begin
                     state_d[p] = S_HOLD;
                     cnt_d[p]   = '0;
                  end else begin
                     state_d[p] = S_WAIT;
                     cnt_d[p]   = CW'(1);
                  end
               end
            end
            S_WAIT: begin
               strobe_raw[p] = 1'b1;
               busy_raw[p]   = 1'b1;
               if (done[p]) begin
                  state_d[p] = S_HOLD;
                  cnt_d[p]   = '0;
               end else if (cnt_q[p] == CW'(TIMEOUT - 1)) begin
                  // Timeout abort: set beats a same-cycle clear.
                  state_d[p] = S_HOLD;
                  cnt_d[p]   = '0;
                  err_d[p]   = 1'b1;
               end else if (cnt_q[p] != {CW{1'b1}}) begin
                  cnt_d[p]   = cnt_q[p] + CW'(1);
               end
            end
            S_HOLD: begin
               state_d[p] = S_IDLE;
            end
            default: begin
               state_d[p] = S_IDLE;
               cnt_d[p]   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int p = 0; p < PORTS; p++) begin
            state_q[p] <= S_IDLE;
            cnt_q[p]   <= '0;
         end
         err_q <= '0;
      end else begin
         for (int p = 0; p < PORTS; p++) begin
            state_q[p] <= state_d[p];
            cnt_q[p]   <= cnt_d[p];
         end
         err_q <= err_d;
      end
   end

   // While reset is held the strobe and stall terms are forced off.
   assign mem_strobe = RST ? '0 : strobe_raw;
   assign busy       = RST ? '0 : busy_raw;
   assign pending    = mem_strobe & ~done;
   assign err        = err_q;

   always_comb begin
      stall = '0;
      for (int p = 0; p < PORTS; p++) begin
         for (int s = 0; s <= STAGES; s++) begin
            stall[s] = stall[s] | (pending[p] & HOLD_MASK[p*(STAGES+1) + s]);
         end
      end
   end

   always_comb begin
      dbg_state = '0;
      for (int p = 0; p < PORTS; p++) begin
         dbg_state[2*p +: 2] = state_q[p];
      end
   end

   assign enable_out    = enable_in & ~stall[STAGES-1:0];
   assign enable_pc_out = enable_pc_in & ~stall[STAGES];
   assign step          = enable_pc_out;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Directed bench for mem_stall_ctrl: driver pushes per-cycle expected outputs,
// a negedge monitor pops and compares them.
module tb_mem_stall_ctrl;

   localparam int STAGES  = 4;
   localparam int PORTS   = 2;
   localparam int TIMEOUT = 16;
   localparam logic [9:0] MASK = 10'b11111_10001;
   localparam int W = 12;

   logic                CLK = 1'b0;
   logic                RST;
   logic [STAGES-1:0]   enable_in;
   logic                enable_pc_in;
   logic [PORTS-1:0]    req, done, err_clr;
   logic [STAGES-1:0]   enable_out;
   logic                enable_pc_out;
   logic [PORTS-1:0]    mem_strobe, busy, err;
   logic                step;
   logic [2*PORTS-1:0]  dbg_state;

   logic [W-1:0] exp_q[$];
   string        tag_q[$];
   int           n_checks = 0;
   int           n_errors = 0;

   mem_stall_ctrl #(
      .STAGES(STAGES), .PORTS(PORTS), .TIMEOUT(TIMEOUT), .HOLD_MASK(MASK)
   ) dut (
      .CLK(CLK), .RST(RST), .enable_in(enable_in), .enable_pc_in(enable_pc_in),
      .req(req), .done(done), .err_clr(err_clr), .enable_out(enable_out),
      .enable_pc_out(enable_pc_out), .mem_strobe(mem_strobe), .busy(busy),
      .err(err), .step(step), .dbg_state(dbg_state)
   );

   always #5 CLK = ~CLK;

   // One cycle: drive inputs after the edge and queue the outputs expected in that cycle.
   task automatic cyc(input string tag, input logic rst, input logic [3:0] ein,
                      input logic epc, input logic [1:0] rq, input logic [1:0] dn,
                      input logic [1:0] clr, input logic [3:0] x_en, input logic x_pc,
                      input logic [1:0] x_st, input logic [1:0] x_bz, input logic [1:0] x_er);
      @(posedge CLK);
      #1;
      RST = rst; enable_in = ein; enable_pc_in = epc;
      req = rq; done = dn; err_clr = clr;
      exp_q.push_back({x_en, x_pc, x_st, x_bz, x_er, x_pc});
      tag_q.push_back(tag);
   endtask

   always @(negedge CLK) begin
      if (exp_q.size() > 0) begin
         logic [W-1:0] e, a;
         string t;
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         a = {enable_out, enable_pc_out, mem_strobe, busy, err, step};
         n_checks++;
         if (a !== e) begin
            n_errors++;
            $display("FAIL %s: got en=%b pc=%b st=%b bz=%b er=%b step=%b, want en=%b pc=%b st=%b bz=%b er=%b step=%b",
                     t, a[11:8], a[7], a[6:5], a[4:3], a[2:1], a[0],
                     e[11:8], e[7], e[6:5], e[4:3], e[2:1], e[0]);
         end
      end
   end

   initial begin
      RST = 1'b1; enable_in = 4'hF; enable_pc_in = 1'b1;
      req = '0; done = '0; err_clr = '0;

      // Reset held: strobe/busy forced off, enables pass through.
      cyc("rst0",     1, 4'hF, 1, 2'b11, 2'b00, 2'b00, 4'hF, 1, 2'b00, 2'b00, 2'b00);
      cyc("rst1",     1, 4'hF, 1, 2'b11, 2'b00, 2'b00, 4'hF, 1, 2'b00, 2'b00, 2'b00);
      cyc("rst_pass", 1, 4'h5, 0, 2'b11, 2'b00, 2'b00, 4'h5, 0, 2'b00, 2'b00, 2'b00);

      // Zero-wait on port 0.
      cyc("zw_c0",   0, 4'hF, 1, 2'b01, 2'b01, 2'b00, 4'hF, 1, 2'b01, 2'b00, 2'b00);
      cyc("zw_hold", 0, 4'hF, 1, 2'b01, 2'b00, 2'b00, 4'hF, 1, 2'b00, 2'b00, 2'b00);
      cyc("zw_idle", 0, 4'hF, 1, 2'b00, 2'b00, 2'b00, 4'hF, 1, 2'b00, 2'b00, 2'b00);

      // Wait-state read on port 1 (full mask).
      cyc("wr_c0", 0, 4'hF, 1, 2'b10, 2'b00, 2'b00, 4'h0, 0, 2'b10, 2'b00, 2'b00);
      cyc("wr_c1", 0, 4'hF, 1, 2'b10, 2'b00, 2'b00, 4'h0, 0, 2'b10, 2'b10, 2'b00);
      cyc("wr_c2", 0, 4'hF, 1, 2'b10, 2'b00, 2'b00, 4'h0, 0, 2'b10, 2'b10, 2'b00);
      cyc("wr_c3", 0, 4'hF, 1, 2'b10, 2'b10, 2'b00, 4'hF, 1, 2'b10, 2'b10, 2'b00);
      cyc("wr_c4", 0, 4'hF, 1, 2'b10, 2'b00, 2'b00, 4'hF, 1, 2'b00, 2'b00, 2'b00);
      cyc("wr_c5", 0, 4'hF, 1, 2'b00, 2'b00, 2'b00, 4'hF, 1, 2'b00, 2'b00, 2'b00);

      // Partial mask on port 0: stage 0 and PC only.
      cyc("pm_c0", 0, 4'hF, 1, 2'b01, 2'b00, 2'b00, 4'hE, 0, 2'b01, 2'b00, 2'b00);
      cyc("pm_c1", 0, 4'h7, 1, 2'b01, 2'b00, 2'b00, 4'h6, 0, 2'b01, 2'b01, 2'b00);
      cyc("pm_c2", 0, 4'hF, 1, 2'b01, 2'b00, 2'b00, 4'hE, 0, 2'b01, 2'b01, 2'b00);
      cyc("pm_c3", 0, 4'hF, 1, 2'b01, 2'b01, 2'b00, 4'hF, 1, 2'b01, 2'b01, 2'b00);
      cyc("pm_c4", 0, 4'hF, 1, 2'b00, 2'b00, 2'b00, 4'hF, 1, 2'b00, 2'b00, 2'b00);
      cyc("pm_c5", 0, 4'hA, 0, 2'b00, 2'b00, 2'b00, 4'hA, 0, 2'b00, 2'b00, 2'b00);

      // Overlap: port 0 done at c2, port 1 done at c5.
      cyc("ov_c0", 0, 4'hF, 1, 2'b11, 2'b00, 2'b00, 4'h0, 0, 2'b11, 2'b00, 2'b00);
      cyc("ov_c1", 0, 4'hF, 1, 2'b11, 2'b00, 2'b00, 4'h0, 0, 2'b11, 2'b11, 2'b00);
      cyc("ov_c2", 0, 4'hF, 1, 2'b11, 2'b01, 2'b00, 4'h0, 0, 2'b11, 2'b11, 2'b00);
      cyc("ov_c3", 0, 4'hF, 1, 2'b10, 2'b00, 2'b00, 4'h0, 0, 2'b10, 2'b10, 2'b00);
      cyc("ov_c4", 0, 4'hF, 1, 2'b10, 2'b00, 2'b00, 4'h0, 0, 2'b10, 2'b10, 2'b00);
      cyc("ov_c5", 0, 4'hF, 1, 2'b10, 2'b10, 2'b00, 4'hF, 1, 2'b10, 2'b10, 2'b00);
      cyc("ov_c6", 0, 4'hF, 1, 2'b00, 2'b00, 2'b00, 4'hF, 1, 2'b00, 2'b00, 2'b00);

      // Timeout on port 0: stall cycles 0..15, then HOLD with err set.
      cyc("to0_c0", 0, 4'hF, 1, 2'b01, 2'b00, 2'b00, 4'hE, 0, 2'b01, 2'b00, 2'b00);
      for (int i = 1; i < TIMEOUT; i++)
         cyc("to0_wait", 0, 4'hF, 1, 2'b01, 2'b00, 2'b00, 4'hE, 0, 2'b01, 2'b01, 2'b00);
      cyc("to0_hold_late_done", 0, 4'hF, 1, 2'b01, 2'b01, 2'b00, 4'hF, 1, 2'b00, 2'b00, 2'b01);
      cyc("to0_idle_spur_done", 0, 4'hF, 1, 2'b00, 2'b01, 2'b00, 4'hF, 1, 2'b00, 2'b00, 2'b01);
      cyc("to0_clr_pulse",      0, 4'hF, 1, 2'b00, 2'b00, 2'b01, 4'hF, 1, 2'b00, 2'b00, 2'b01);
      cyc("to0_cleared",        0, 4'hF, 1, 2'b00, 2'b00, 2'b00, 4'hF, 1, 2'b00, 2'b00, 2'b00);

      // Timeout on port 1 with a clear in the setting cycle: set wins.
      cyc("to1_c0", 0, 4'hF, 1, 2'b10, 2'b00, 2'b00, 4'h0, 0, 2'b10, 2'b00, 2'b00);
      for (int i = 1; i < TIMEOUT - 1; i++)
         cyc("to1_wait", 0, 4'hF, 1, 2'b10, 2'b00, 2'b00, 4'h0, 0, 2'b10, 2'b10, 2'b00);
      cyc("to1_set_vs_clr", 0, 4'hF, 1, 2'b10, 2'b00, 2'b10, 4'h0, 0, 2'b10, 2'b10, 2'b00);
      cyc("to1_hold",       0, 4'hF, 1, 2'b10, 2'b00, 2'b00, 4'hF, 1, 2'b00, 2'b00, 2'b10);
      cyc("to1_idle",       0, 4'hF, 1, 2'b00, 2'b00, 2'b00, 4'hF, 1, 2'b00, 2'b00, 2'b10);

      // Reset mid-wait on port 1: no HOLD afterwards, so req restarts at once.
      cyc("rmw_c0",  0, 4'hF, 1, 2'b10, 2'b00, 2'b00, 4'h0, 0, 2'b10, 2'b00, 2'b10);
      cyc("rmw_c1",  0, 4'hF, 1, 2'b10, 2'b00, 2'b00, 4'h0, 0, 2'b10, 2'b10, 2'b10);
      cyc("rmw_rst", 1, 4'hF, 1, 2'b10, 2'b00, 2'b00, 4'hF, 1, 2'b00, 2'b00, 2'b10);
      cyc("rmw_c3",  0, 4'hF, 1, 2'b10, 2'b00, 2'b00, 4'h0, 0, 2'b10, 2'b00, 2'b00);
      n_checks++;
      if (dbg_state !== 4'b0000) begin
         n_errors++;
         $display("FAIL rmw_state: got %b, want 0000", dbg_state);
      end
      cyc("rmw_c4",  0, 4'hF, 1, 2'b10, 2'b10, 2'b00, 4'hF, 1, 2'b10, 2'b10, 2'b00);
      cyc("rmw_c5",  0, 4'hF, 1, 2'b00, 2'b00, 2'b00, 4'hF, 1, 2'b00, 2'b00, 2'b00);
      cyc("rmw_c6",  0, 4'hF, 1, 2'b00, 2'b00, 2'b00, 4'hF, 1, 2'b00, 2'b00, 2'b00);

      repeat (3) @(posedge CLK);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
